multicycle_control_unit: RTL

Moore-style FSM that sequences the multi-cycle RV32I datapath: PC, instruction/data memory, register file and ALU.
Steps each instruction through IF/ID/EX/MEM/WB. Drives register-file write enable, memory strobes, mux selects and the ecall/halt handshake with the register file.
Stretches memory states for a fixed memory latency.

---
 rtl/multicycle_control_unit.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: Moore FSM sequencing a multi-cycle RV32I datapath
// through IF/ID/EX/MEM/WB. Memory states (IF, MEM) are held MEM_LATENCY cycles.
// Optional build macro MC_PERF_CNT_EN adds retired-instruction and active-cycle
// counters; without it both counter ports are tied to zero.
module multicycle_control_unit #(
    parameter int MEM_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  opcode,
    input  logic        is_halted,
    output logic        pc_write,
    output logic        pc_write_cond,
    output logic        pc_source,
    output logic        i_or_d,
    output logic        mem_read,
    output logic        mem_write,
    output logic        ir_write,
    output logic [1:0]  mem_to_reg,
    output logic        reg_write,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic        is_ecall,
    output logic        halted,
    output logic [31:0] instr_count,
    output logic [31:0] cycle_count
);

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd5
    } state_t;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_ECALL = 7'b1110011;

    // Final wait count of a memory state; wait_cnt never goes beyond it.
    localparam logic [3:0] LAST_WAIT = 4'(MEM_LATENCY - 1);

    state_t     state_q, state_d;
    logic [3:0] wait_q, wait_d;

    // State and memory-wait counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IF;
            wait_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // Next-state and Moore output decode; everything is forced low during reset.
    always_comb begin
        state_d       = state_q;
        wait_d        = wait_q;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 2'b00;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        is_ecall      = 1'b0;
        halted        = 1'b0;
        unique case (state_q)
            S_IF: begin
                mem_read = 1'b1;
                if (wait_q == LAST_WAIT) begin
                    ir_write  = 1'b1;
                    pc_write  = 1'b1;
                    alu_src_b = 2'b01;
                    state_d   = S_ID;
                    wait_d    = 4'd0;
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            S_ID: begin
                // Branch/JAL target is precomputed into ALUOut here.
                alu_src_b = 2'b10;
                if (opcode == OP_ECALL) begin
                    is_ecall = 1'b1;
                    state_d  = is_halted ? S_HALT : S_IF;
                end else begin
                    state_d = S_EX;
                end
            end
            S_EX: begin
                state_d = S_IF;
                case (opcode)
                    OP_R: begin
                        alu_src_a = 1'b1;
                        alu_op    = 2'b10;
                        state_d   = S_WB;
                    end
                    OP_I: begin
                        alu_src_a = 1'b1;
                        alu_src_b = 2'b10;
                        alu_op    = 2'b10;
                        state_d   = S_WB;
                    end
                    OP_LOAD, OP_STORE: begin
                        alu_src_a = 1'b1;
                        alu_src_b = 2'b10;
                        state_d   = S_MEM;
                    end
                    OP_BR: begin
                        alu_src_a     = 1'b1;
                        alu_op        = 2'b01;
                        pc_write_cond = 1'b1;
                        pc_source     = 1'b1;
                    end
                    OP_JAL: begin
                        reg_write  = 1'b1;
                        mem_to_reg = 2'b10;
                        pc_write   = 1'b1;
                        pc_source  = 1'b1;
                    end
                    OP_JALR: begin
                        alu_src_a = 1'b1;
                        alu_src_b = 2'b10;
                        state_d   = S_WB;
                    end
                    default: ;  // unknown opcode retires as a NOP
                endcase
            end
            S_MEM: begin
                i_or_d    = 1'b1;
                mem_read  = (opcode == OP_LOAD);
                mem_write = (opcode == OP_STORE);
                if (wait_q == LAST_WAIT) begin
                    state_d = (opcode == OP_LOAD) ? S_WB : S_IF;
                    wait_d  = 4'd0;
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            S_WB: begin
                reg_write = 1'b1;
                state_d   = S_IF;
                if (opcode == OP_LOAD) begin
                    mem_to_reg = 2'b01;
                end else if (opcode == OP_JALR) begin
                    mem_to_reg = 2'b10;
                    pc_write   = 1'b1;
                    pc_source  = 1'b1;
                end
            end
            S_HALT: halted = 1'b1;
            default: state_d = S_IF;
        endcase
        if (reset) begin
            pc_write      = 1'b0;
            pc_write_cond = 1'b0;
            pc_source     = 1'b0;
            i_or_d        = 1'b0;
            mem_read      = 1'b0;
            mem_write     = 1'b0;
            ir_write      = 1'b0;
            mem_to_reg    = 2'b00;
            reg_write     = 1'b0;
            alu_src_a     = 1'b0;
            alu_src_b     = 2'b00;
            alu_op        = 2'b00;
            is_ecall      = 1'b0;
            halted        = 1'b0;
        end
    end

`ifdef MC_PERF_CNT_EN
    logic [31:0] instr_q, cycle_q;
    logic        retire;

    // An instruction retires on any return to IF; entering HALT is not a retire.
    assign retire = (state_d == S_IF) && (state_q != S_IF) && (state_q != S_HALT);

    // Performance counters, wrapping naturally at 2^32.
    always_ff @(posedge clk) begin
        if (reset) begin
            instr_q <= 32'd0;
            cycle_q <= 32'd0;
        end else begin
            if (retire)            instr_q <= instr_q + 32'd1;
            if (state_q != S_HALT) cycle_q <= cycle_q + 32'd1;
        end
    end

    assign instr_count = instr_q;
    assign cycle_count = cycle_q;
`else
    assign instr_count = 32'd0;
    assign cycle_count = 32'd0;
`endif

endmodule
